// File: rtl/serial_alu_sequencer.sv
// Bit-serial sequencer driving an external combinational 1-bit ALU, LSB first.
// Define SERIAL_ALU_CARRY_IN_EN to add c_in_ext as the initial carry/borrow for word chaining.
module serial_alu_sequencer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [2:0]   op_in,
`ifdef SERIAL_ALU_CARRY_IN_EN
    input  logic         c_in_ext,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         carry_out,
    output logic         zero,
    output logic         parity,
    output logic         alu_a,
    output logic         alu_b,
    output logic         alu_c_in,
    output logic [2:0]   alu_op,
    input  logic         alu_o,
    input  logic         alu_c_out
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [N-1:0]   a_sr;
    logic [N-1:0]   b_sr;
    logic [2:0]     op_reg;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   res_next;
    logic           carry_init;

`ifdef SERIAL_ALU_CARRY_IN_EN
    assign carry_init = c_in_ext;
`else
    assign carry_init = 1'b0;
`endif

    assign res_next = {alu_o, result[N-1:1]};

    // ALU feed is gated by the registered state, so start never reaches it combinationally.
    assign alu_a    = (state == RUN) & a_sr[0];
    assign alu_b    = (state == RUN) & b_sr[0];
    assign alu_c_in = (state == RUN) & carry;
    assign alu_op   = op_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b1;
            parity    <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            op_reg    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        a_sr      <= a_in;
                        b_sr      <= b_in;
                        op_reg    <= op_in;
                        carry     <= carry_init;
                        cnt       <= '0;
                        result    <= '0;
                        carry_out <= 1'b0;
                        zero      <= 1'b1;
                        parity    <= 1'b0;
                    end
                end
                RUN: begin
                    result <= res_next;
                    carry  <= alu_c_out;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + 1'b1;
                    // Flags are taken from the final shifted word so they are valid with done.
                    if (cnt == CW'(N - 1)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        carry_out <= alu_c_out;
                        zero      <= ~|res_next;
                        parity    <= ^res_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
